// File: rtl/div_unit_pkg.sv
// Shared ALU constants for the iterative divider: unit select, op codes and FSM encoding.
// The function-control decoder and the ALU output mux use the same definitions.
package div_unit_pkg;

  localparam logic [2:0] DIV_UNIT_SEL = 3'b101;
  localparam logic       DIV_OP_QUOT  = 1'b0;
  localparam logic       DIV_OP_REM   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the Execute stage and the divider.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            div_op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  modport master (
    output start, div_op, dividend, divisor,
    input  result, busy, done
  );

  modport slave (
    input  start, div_op, dividend, divisor,
    output result, busy, done
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift/trial-subtract iteration producing one quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] q_next
);
  logic [XLEN:0] r_shift;
  logic [XLEN:0] trial;

  assign r_shift = {rem, q[XLEN-1]};
  assign trial   = r_shift - {1'b0, divisor};

  // A borrow means the shifted remainder stays; it is then below the divisor,
  // so its top bit is zero and the low XLEN bits carry the whole value.
  assign rem_next = trial[XLEN] ? r_shift[XLEN-1:0] : trial[XLEN-1:0];
  assign q_next   = {q[XLEN-2:0], ~trial[XLEN]};
endmodule

// File: rtl/div_unit.sv
// Iterative unsigned divider (DIVU/REMU): one quotient bit per cycle, busy stalls the pipeline.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  div_state_e      state_reg, state_next;
  logic [XLEN-1:0] rem_reg, rem_step;
  logic [XLEN-1:0] q_reg, q_step;
  logic [XLEN-1:0] divisor_reg;
  logic [XLEN-1:0] result_reg;
  logic            div_op_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic            accept;
  logic            div_zero;

  assign accept   = bus.start && ((state_reg == IDLE) || (state_reg == FIN));
  assign div_zero = (bus.divisor == '0);

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_reg),
    .q       (q_reg),
    .divisor (divisor_reg),
    .rem_next(rem_step),
    .q_next  (q_step)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, FIN: state_next = accept ? (div_zero ? FIN : CALC) : IDLE;
      CALC:      state_next = (cnt_reg == '0) ? FIN : CALC;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      q_reg       <= '0;
      divisor_reg <= '0;
      result_reg  <= '0;
      div_op_reg  <= DIV_OP_QUOT;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        div_op_reg  <= bus.div_op;
        divisor_reg <= bus.divisor;
        q_reg       <= bus.dividend;
        rem_reg     <= '0;
        cnt_reg     <= CNT_W'(XLEN - 1);
        // Divide-by-zero skips CALC, so its RISC-V result is loaded on the way into FIN.
        if (div_zero) begin
          result_reg <= (bus.div_op == DIV_OP_REM) ? bus.dividend : '1;
        end
      end else if (state_reg == CALC) begin
        rem_reg <= rem_step;
        q_reg   <= q_step;
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (cnt_reg == '0) begin
          result_reg <= (div_op_reg == DIV_OP_REM) ? rem_step : q_step;
        end
      end
    end
  end

  assign bus.result = result_reg;
  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == FIN);
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results queued at start, popped at done.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int MAX_LAT = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.XLEN(XLEN)) bus ();

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [XLEN-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] dd, input logic [XLEN-1:0] dv,
                                            input logic op);
    if (dv == '0) return (op == DIV_OP_REM) ? dd : '1;
    return (op == DIV_OP_REM) ? (dd % dv) : (dd / dv);
  endfunction

  // Pulses start for one cycle and records the expected result.
  task automatic launch(input logic [XLEN-1:0] dd, input logic [XLEN-1:0] dv, input logic op);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.div_op   = op;
    exp_q.push_back(model(dd, dv, op));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Advances negedge by negedge until done, bounded; lat is cycles since the start cycle.
  task automatic wait_done(input int lat0, output int lat, output int busy_cycles);
    lat = lat0;
    busy_cycles = 0;
    while (1) begin
      if (bus.busy) busy_cycles++;
      if (bus.done || lat >= MAX_LAT) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.result !== '0) $display("FAIL reset_result: got %h want 0", bus.result); else n_pass++;
    rst = 1'b0;
    $display("reset: busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
  endtask

  task automatic test_basic;
    logic [XLEN-1:0] dd_t[4];
    logic [XLEN-1:0] dv_t[4];
    logic            op_t[4];
    logic [XLEN-1:0] exp;
    int lat, bc;
    dd_t = '{32'd100, 32'd100, 32'd5, 32'd5};
    dv_t = '{32'd7, 32'd7, 32'd9, 32'd9};
    op_t = '{DIV_OP_QUOT, DIV_OP_REM, DIV_OP_QUOT, DIV_OP_REM};
    for (int i = 0; i < 4; i++) begin
      launch(dd_t[i], dv_t[i], op_t[i]);
      wait_done(1, lat, bc);
      exp = exp_q.pop_front();
      $display("basic %0d/%0d op=%b: result=%0d lat=%0d busy=%0d", dd_t[i], dv_t[i], op_t[i], bus.result, lat, bc);
      n_checks++; if (bus.result !== exp) $display("FAIL basic_result[%0d]: got %h want %h", i, bus.result, exp); else n_pass++;
      n_checks++; if (lat != XLEN + 1) $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, XLEN + 1); else n_pass++;
      n_checks++; if (bc != XLEN + 1) $display("FAIL basic_busy_cycles[%0d]: got %0d want %0d", i, bc, XLEN + 1); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL basic_done_pulse[%0d]: got done=%b busy=%b want 0 0", i, bus.done, bus.busy); else n_pass++;
    end
  endtask

  task automatic test_extremes;
    logic [XLEN-1:0] dd_t[5];
    logic [XLEN-1:0] dv_t[5];
    logic            op_t[5];
    logic [XLEN-1:0] exp;
    int lat, bc;
    dd_t = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    dv_t = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2};
    op_t = '{DIV_OP_QUOT, DIV_OP_REM, DIV_OP_QUOT, DIV_OP_REM, DIV_OP_QUOT};
    for (int i = 0; i < 5; i++) begin
      launch(dd_t[i], dv_t[i], op_t[i]);
      wait_done(1, lat, bc);
      exp = exp_q.pop_front();
      $display("extreme %h/%h op=%b: result=%h lat=%0d", dd_t[i], dv_t[i], op_t[i], bus.result, lat);
      n_checks++; if (bus.result !== exp) $display("FAIL extreme_result[%0d]: got %h want %h", i, bus.result, exp); else n_pass++;
      n_checks++; if (lat != XLEN + 1) $display("FAIL extreme_latency[%0d]: got %0d want %0d", i, lat, XLEN + 1); else n_pass++;
    end
  endtask

  task automatic test_div_zero;
    logic [XLEN-1:0] exp;
    logic            op_t[2];
    int lat, bc;
    op_t = '{DIV_OP_QUOT, DIV_OP_REM};
    for (int i = 0; i < 2; i++) begin
      launch(32'h1234, 32'h0, op_t[i]);
      wait_done(1, lat, bc);
      exp = exp_q.pop_front();
      $display("divzero op=%b: result=%h lat=%0d busy=%0d", op_t[i], bus.result, lat, bc);
      n_checks++; if (bus.result !== exp) $display("FAIL divzero_result[%0d]: got %h want %h", i, bus.result, exp); else n_pass++;
      n_checks++; if (lat != 1) $display("FAIL divzero_latency[%0d]: got %0d want 1", i, lat); else n_pass++;
      n_checks++; if (bc != 1) $display("FAIL divzero_busy_cycles[%0d]: got %0d want 1", i, bc); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    logic [XLEN-1:0] exp;
    int lat, bc;
    launch(32'd1000, 32'd3, DIV_OP_QUOT);
    repeat (4) @(negedge clk);
    // A start during CALC with a zero divisor would finish at once if it were wrongly taken.
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd0;
    bus.div_op   = DIV_OP_REM;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6, lat, bc);
    exp = exp_q.pop_front();
    $display("ignore_start 1000/3: result=%0d lat=%0d", bus.result, lat);
    n_checks++; if (bus.result !== exp) $display("FAIL ignore_result: got %h want %h", bus.result, exp); else n_pass++;
    n_checks++; if (lat != XLEN + 1) $display("FAIL ignore_latency: got %0d want %0d", lat, XLEN + 1); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [XLEN-1:0] exp;
    int lat, bc;
    launch(32'd200, 32'd9, DIV_OP_QUOT);
    wait_done(1, lat, bc);
    exp = exp_q.pop_front();
    $display("b2b first 200/9: result=%0d lat=%0d", bus.result, lat);
    n_checks++; if (bus.result !== exp) $display("FAIL b2b_first_result: got %h want %h", bus.result, exp); else n_pass++;
    // Still in the FIN cycle: this start must be taken back-to-back.
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd4;
    bus.div_op   = DIV_OP_REM;
    exp_q.push_back(model(32'd77, 32'd4, DIV_OP_REM));
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1, lat, bc);
    exp = exp_q.pop_front();
    $display("b2b second 77%%4: result=%0d lat=%0d", bus.result, lat);
    n_checks++; if (bus.result !== exp) $display("FAIL b2b_second_result: got %h want %h", bus.result, exp); else n_pass++;
    n_checks++; if (lat != XLEN + 1) $display("FAIL b2b_second_latency: got %0d want %0d", lat, XLEN + 1); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      $display("hold cycle %0d: result=%0d busy=%b", i, bus.result, bus.busy);
      n_checks++; if (bus.result !== exp) $display("FAIL hold_result[%0d]: got %h want %h", i, bus.result, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    logic [XLEN-1:0] exp;
    logic            seen_done;
    int lat, bc;
    launch(32'd100, 32'd7, DIV_OP_QUOT);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    $display("reset_mid: busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.result !== '0) $display("FAIL rstmid_result: got %h want 0", bus.result); else n_pass++;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) $display("FAIL rstmid_no_done: got done=%b want 0", seen_done); else n_pass++;
    launch(32'd50, 32'd5, DIV_OP_QUOT);
    wait_done(1, lat, bc);
    exp = exp_q.pop_front();
    $display("after reset 50/5: result=%0d lat=%0d", bus.result, lat);
    n_checks++; if (bus.result !== exp) $display("FAIL rstmid_fresh_result: got %h want %h", bus.result, exp); else n_pass++;
    n_checks++; if (lat != XLEN + 1) $display("FAIL rstmid_fresh_latency: got %0d want %0d", lat, XLEN + 1); else n_pass++;
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.div_op   = DIV_OP_QUOT;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
